// File: rtl/maze_solver_dfs.sv
// Depth-first maze search from (0,0) to (N-1,N-1) over an external 1-bit maze
// memory, keeping the move path on an internal stack and replaying it on Run.
module maze_solver_dfs #(
    parameter int COORD_W     = 4,
    parameter int STACK_DEPTH = 256,
    parameter int PTR_W       = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Start,
    input  logic               Run,
    input  logic               Dout,
    output logic               Fail,
    output logic               Done,
    output logic               Din,
    output logic               RD,
    output logic               WR,
    output logic [1:0]         Move,
    output logic               Move_valid,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    output logic               Overflow,
    output logic [PTR_W-1:0]   Path_len
);
    // sp has to reach STACK_DEPTH itself (full stack), so it is wider than a stack index.
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [COORD_W-1:0] MAX_C   = '1;
    localparam logic [COORD_W-1:0] ONE_C   = COORD_W'(1);
    localparam logic [SP_W-1:0]    ONE_SP  = SP_W'(1);
    localparam logic [SP_W-1:0]    FULL_SP = SP_W'(STACK_DEPTH);
    localparam logic [2:0]         DIR_INC = 3'd1;

    typedef enum logic [3:0] {
        S_IDLE, S_MARK, S_PROBE, S_READ, S_CHECK,
        S_POP, S_DONE, S_REPLAY, S_RWAIT, S_FAIL
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               ok;
    } cell_t;

    // One step from (x,y) in direction d; ok=0 when the step would leave the grid.
    function automatic cell_t step_cell(input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y,
                                        input logic [1:0]         d);
        cell_t c;
        c.x  = x;
        c.y  = y;
        c.ok = 1'b1;
        case (dir_e'(d))
            DIR_UP:    begin c.ok = (y != '0);    c.y = y - ONE_C; end
            DIR_RIGHT: begin c.ok = (x != MAX_C); c.x = x + ONE_C; end
            DIR_LEFT:  begin c.ok = (x != '0);    c.x = x - ONE_C; end
            default:   begin c.ok = (y != MAX_C); c.y = y + ONE_C; end
        endcase
        return c;
    endfunction

    state_e             state_q, state_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [COORD_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [2:0]         dir_q, dir_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [SP_W-1:0]    idx_q, idx_d;
    logic               ovf_q, ovf_d;

    logic [1:0]         stack_q [STACK_DEPTH];
    logic [IDX_W-1:0]   rd_idx;
    logic [1:0]         top_dir;
    logic               push_en;
    logic [1:0]         step_dir;
    cell_t              step;

    // POP backs off along the opposite of the popped move; ~d swaps up/down and left/right.
    assign rd_idx   = (state_q == S_POP) ? IDX_W'(sp_q - ONE_SP) : IDX_W'(idx_q);
    assign top_dir  = stack_q[rd_idx];
    assign step_dir = (state_q == S_POP) ? ~top_dir : dir_q[1:0];
    assign step     = step_cell(cur_x_q, cur_y_q, step_dir);

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        dir_d    = dir_q;
        sp_d     = sp_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        push_en  = 1'b0;
        case (state_q)
            S_IDLE: if (Start) begin
                state_d = S_MARK;
                cur_x_d = '0;
                cur_y_d = '0;
                sp_d    = '0;
            end
            S_MARK: begin
                if (cur_x_q == MAX_C && cur_y_q == MAX_C) begin
                    state_d = S_DONE;
                end else begin
                    dir_d   = '0;
                    state_d = S_PROBE;
                end
            end
            S_PROBE: begin
                if (dir_q[2]) begin
                    state_d = S_POP;
                end else if (step.ok) begin
                    cand_x_d = step.x;
                    cand_y_d = step.y;
                    state_d  = S_READ;
                end else begin
                    dir_d = dir_q + DIR_INC;
                end
            end
            S_READ: state_d = S_CHECK;
            S_CHECK: begin
                if (Dout) begin
                    dir_d   = dir_q + DIR_INC;
                    state_d = S_PROBE;
                end else if (sp_q == FULL_SP) begin
                    ovf_d   = 1'b1;
                    state_d = S_FAIL;
                end else begin
                    push_en = 1'b1;
                    sp_d    = sp_q + ONE_SP;
                    cur_x_d = cand_x_q;
                    cur_y_d = cand_y_q;
                    state_d = S_MARK;
                end
            end
            S_POP: begin
                if (sp_q == '0) begin
                    state_d = S_FAIL;
                end else begin
                    sp_d    = sp_q - ONE_SP;
                    cur_x_d = step.x;
                    cur_y_d = step.y;
                    dir_d   = {1'b0, top_dir} + DIR_INC;
                    state_d = S_PROBE;
                end
            end
            S_DONE: if (Run) begin
                idx_d   = '0;
                state_d = S_REPLAY;
            end
            S_REPLAY: begin
                if (sp_q == '0 || idx_q == sp_q - ONE_SP) begin
                    state_d = S_RWAIT;
                end else begin
                    idx_d = idx_q + ONE_SP;
                end
            end
            S_RWAIT: if (!Run) state_d = S_DONE;
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            cand_x_q <= '0;
            cand_y_q <= '0;
            dir_q    <= '0;
            sp_q     <= '0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            dir_q    <= dir_d;
            sp_q     <= sp_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the stack is plain storage with no reset; entries at or above sp are never read.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            stack_q[IDX_W'(sp_q)] <= dir_q[1:0];
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
        WR         = (state_q == S_MARK);
        Din        = (state_q == S_MARK);
        RD         = (state_q == S_READ);
        Done       = (state_q inside {S_DONE, S_REPLAY, S_RWAIT});
        Fail       = (state_q == S_FAIL);
        Overflow   = ovf_q;
        Move_valid = (state_q == S_REPLAY) && (sp_q != '0);
        Move       = Move_valid ? top_dir : 2'b00;
        Path_len   = Done ? PTR_W'(sp_q) : '0;
        if (state_q == S_READ || state_q == S_CHECK) begin
            X = cand_x_q;
            Y = cand_y_q;
        end else begin
            X = cur_x_q;
            Y = cur_y_q;
        end
    end

endmodule

// File: tb/tb_maze_solver_dfs.sv
// Bench for maze_solver_dfs: two instances (stack depth 16 and 4) on the same 4x4 mazes,
// checked against a software DFS that predicts memory accesses, outcome and replayed path.
module tb_maze_solver_dfs;
    localparam int CW = 2;
    localparam int N  = 4;
    localparam int PW = 5;

    logic CLK = 1'b0;
    logic RST, Start, Run, load;
    logic maze [N*N];
    logic mem_a [N*N];
    logic mem_b [N*N];
    logic dout_a = 1'b0, dout_b = 1'b0;

    logic fail_a, done_a, din_a, rd_a, wr_a, mv_a, ovf_a;
    logic fail_b, done_b, din_b, rd_b, wr_b, mv_b, ovf_b;
    logic [1:0] move_a, move_b;
    logic [CW-1:0] x_a, y_a, x_b, y_b;
    logic [PW-1:0] len_a, len_b;

    always #5 CLK = ~CLK;

    maze_solver_dfs #(.COORD_W(CW), .STACK_DEPTH(16), .PTR_W(PW)) dut_a (
        .CLK(CLK), .RST(RST), .Start(Start), .Run(Run), .Dout(dout_a),
        .Fail(fail_a), .Done(done_a), .Din(din_a), .RD(rd_a), .WR(wr_a),
        .Move(move_a), .Move_valid(mv_a), .X(x_a), .Y(y_a),
        .Overflow(ovf_a), .Path_len(len_a));

    maze_solver_dfs #(.COORD_W(CW), .STACK_DEPTH(4), .PTR_W(PW)) dut_b (
        .CLK(CLK), .RST(RST), .Start(Start), .Run(Run), .Dout(dout_b),
        .Fail(fail_b), .Done(done_b), .Din(din_b), .RD(rd_b), .WR(wr_b),
        .Move(move_b), .Move_valid(mv_b), .X(x_b), .Y(y_b),
        .Overflow(ovf_b), .Path_len(len_b));

    // Maze memories: registered read data, write marks a cell, load copies the bench maze.
    always @(posedge CLK) begin
        if (load) begin
            mem_a <= maze;
            mem_b <= maze;
        end else begin
            if (rd_a) dout_a <= mem_a[int'(y_a)*N + int'(x_a)];
            if (wr_a) mem_a[int'(y_a)*N + int'(x_a)] <= 1'b1;
            if (rd_b) dout_b <= mem_b[int'(y_b)*N + int'(x_b)];
            if (wr_b) mem_b[int'(y_b)*N + int'(x_b)] <= 1'b1;
        end
    end

    typedef struct {
        logic rd, wr, din, done, fail, ovf, mv;
        logic [1:0] mov;
        logic [CW-1:0] x, y;
        logic [PW-1:0] len;
    } obs_t;

    obs_t o [2];
    int n_pass = 0;
    int n_total = 0;
    int exp_rd [2][$];
    int exp_wr [2][$];
    int exp_mv [2][$];
    int m_moves [2][$];
    int m_done [2], m_fail [2], m_ovf [2], m_len [2];
    int rd_cnt [2], wr_cnt [2], mv_cnt [2];
    logic prev_rd [2];
    int prev_addr [2];
    int depth [2] = '{16, 4};

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Software DFS: probe order up,right,left,down; skip off-grid; push on free; pop on exhaustion.
    task automatic build_model(input int k);
        logic vis [N*N];
        int dx [4] = '{0, 1, -1, 0};
        int dy [4] = '{-1, 0, 0, 1};
        int stk [$];
        int cx = 0, cy = 0, d = 0, nx, ny;
        bit mark = 1'b1;
        vis = maze;
        exp_rd[k].delete();
        exp_wr[k].delete();
        m_done[k] = 0; m_fail[k] = 0; m_ovf[k] = 0;
        for (int guard = 0; guard < 10000; guard++) begin
            if (mark) begin
                exp_wr[k].push_back(cy*N + cx);
                vis[cy*N + cx] = 1'b1;
                if (cx == N-1 && cy == N-1) begin m_done[k] = 1; break; end
                d = 0;
                mark = 1'b0;
            end
            if (d == 4) begin
                if (stk.size() == 0) begin m_fail[k] = 1; break; end
                d = stk.pop_back();
                cx -= dx[d];
                cy -= dy[d];
                d++;
                continue;
            end
            nx = cx + dx[d];
            ny = cy + dy[d];
            if (nx < 0 || nx >= N || ny < 0 || ny >= N) begin d++; continue; end
            exp_rd[k].push_back(ny*N + nx);
            if (vis[ny*N + nx]) begin d++; continue; end
            if (stk.size() == depth[k]) begin m_fail[k] = 1; m_ovf[k] = 1; break; end
            stk.push_back(d);
            cx = nx;
            cy = ny;
            mark = 1'b1;
        end
        m_moves[k] = stk;
        m_len[k] = stk.size();
    endtask

    task automatic cycle_check(input int k);
        obs_t c;
        int a;
        c = o[k];
        a = int'(c.y)*N + int'(c.x);
        if (RST) begin
            check($sformatf("reset_outputs[%0d]", k),
                  int'({c.rd, c.wr, c.din, c.done, c.fail, c.ovf, c.mv, c.mov, c.x, c.y, c.len}), 0);
            prev_rd[k] = 1'b0;
            return;
        end
        check($sformatf("rd_wr_exclusive[%0d]", k), int'(c.rd & c.wr), 0);
        check($sformatf("done_fail_exclusive[%0d]", k), int'(c.done & c.fail), 0);
        if (prev_rd[k]) check($sformatf("xy_hold_read_check[%0d]", k), a, prev_addr[k]);
        if (c.wr) begin
            wr_cnt[k]++;
            check($sformatf("din_on_write[%0d]", k), int'(c.din), 1);
            if (exp_wr[k].size() == 0) check($sformatf("unexpected_write[%0d]", k), a, -1);
            else check($sformatf("write_addr[%0d]", k), a, exp_wr[k].pop_front());
        end
        if (c.rd) begin
            rd_cnt[k]++;
            if (exp_rd[k].size() == 0) check($sformatf("unexpected_read[%0d]", k), a, -1);
            else check($sformatf("read_addr[%0d]", k), a, exp_rd[k].pop_front());
        end
        if (c.mv) begin
            mv_cnt[k]++;
            check($sformatf("done_in_replay[%0d]", k), int'(c.done), 1);
            if (exp_mv[k].size() == 0) check($sformatf("unexpected_move[%0d]", k), int'(c.mov), -1);
            else check($sformatf("replay_move[%0d]", k), int'(c.mov), exp_mv[k].pop_front());
        end
        prev_rd[k] = c.rd;
        prev_addr[k] = a;
    endtask

    task automatic tick();
        @(negedge CLK);
        o[0] = '{rd: rd_a, wr: wr_a, din: din_a, done: done_a, fail: fail_a, ovf: ovf_a,
                 mv: mv_a, mov: move_a, x: x_a, y: y_a, len: len_a};
        o[1] = '{rd: rd_b, wr: wr_b, din: din_b, done: done_b, fail: fail_b, ovf: ovf_b,
                 mv: mv_b, mov: move_b, x: x_b, y: y_b, len: len_b};
        for (int k = 0; k < 2; k++) cycle_check(k);
    endtask

    task automatic clear_tracking();
        for (int k = 0; k < 2; k++) begin
            exp_rd[k].delete(); exp_wr[k].delete(); exp_mv[k].delete();
            rd_cnt[k] = 0; wr_cnt[k] = 0; mv_cnt[k] = 0;
            prev_rd[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        clear_tracking();
    endtask

    task automatic load_and_start();
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 2; k++) build_model(k);
        rd_cnt = '{0, 0};
        wr_cnt = '{0, 0};
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!((done_a | fail_a) && (done_b | fail_b)) && n < 3000) begin tick(); n++; end
        check("search_finished_in_time", int'(n < 3000), 1);
        tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("done[%0d]", k), int'(o[k].done), m_done[k]);
            check($sformatf("fail[%0d]", k), int'(o[k].fail), m_fail[k]);
            check($sformatf("overflow[%0d]", k), int'(o[k].ovf), m_ovf[k]);
            check($sformatf("path_len[%0d]", k), int'(o[k].len), m_done[k] ? m_len[k] : 0);
            check($sformatf("reads_left[%0d]", k), exp_rd[k].size(), 0);
            check($sformatf("writes_left[%0d]", k), exp_wr[k].size(), 0);
        end
    endtask

    // Run held well past the longest path: a second replay would show as unexpected moves.
    task automatic replay();
        for (int k = 0; k < 2; k++) begin
            exp_mv[k].delete();
            if (m_done[k] != 0) exp_mv[k] = m_moves[k];
            mv_cnt[k] = 0;
        end
        Run = 1'b1;
        repeat (40) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("replay_count[%0d]", k), mv_cnt[k], m_done[k] ? m_len[k] : 0);
            check($sformatf("replay_moves_left[%0d]", k), exp_mv[k].size(), 0);
        end
        Run = 1'b0;
        repeat (3) tick();
        check("done_after_replay_a", int'(done_a), m_done[0]);
    endtask

    task automatic set_walls();
        for (int i = 0; i < N*N; i++) maze[i] = 1'b1;
    endtask

    task automatic open_cell(input int x, input int y);
        maze[y*N + x] = 1'b0;
    endtask

    task automatic corridor();
        set_walls();
        open_cell(0, 0); open_cell(1, 0); open_cell(1, 1); open_cell(2, 1);
        open_cell(1, 2); open_cell(1, 3); open_cell(2, 3); open_cell(3, 3);
    endtask

    task automatic corridor_literals();
        int lit [6] = '{1, 3, 3, 3, 1, 1};
        check("corridor_model_len", m_moves[0].size(), 6);
        for (int i = 0; i < 6 && i < m_moves[0].size(); i++)
            check($sformatf("corridor_model_move%0d", i), m_moves[0][i], lit[i]);
        check("corridor_len_a", int'(len_a), 6);
        check("corridor_done_a", int'(done_a), 1);
        check("corridor_fail_a", int'(fail_a), 0);
        check("overflow_flag_b", int'(ovf_b), 1);
        check("overflow_fail_b", int'(fail_b), 1);
        check("overflow_done_b", int'(done_b), 0);
    endtask

    initial begin
        int n;
        RST = 1'b1; Start = 1'b1; Run = 1'b0; load = 1'b0;
        set_walls();
        clear_tracking();
        tick(); tick();
        RST = 1'b0; Start = 1'b0;
        repeat (4) tick();
        check("idle_x", int'(x_a), 0);
        check("idle_done", int'(done_a), 0);
        check("idle_no_write", wr_cnt[0], 0);

        // Corridor with a dead end at (2,1); depth-4 instance overflows on the same maze.
        corridor();
        do_reset();
        load_and_start();
        wait_end();
        corridor_literals();
        replay();
        replay();

        // Blocked start: only the right and down neighbours are in-grid and get read.
        set_walls();
        open_cell(0, 0);
        do_reset();
        load_and_start();
        wait_end();
        check("blocked_fail", int'(fail_a), 1);
        check("blocked_overflow", int'(ovf_a), 0);
        check("blocked_len", int'(len_a), 0);
        check("blocked_reads", rd_cnt[0], 2);

        // Reset during the third READ, then a fresh search on a re-initialised memory.
        corridor();
        do_reset();
        load_and_start();
        n = 0;
        while (rd_cnt[0] < 3 && n < 500) begin tick(); n++; end
        check("third_read_seen", int'(rd_cnt[0] >= 3), 1);
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        clear_tracking();
        load_and_start();
        wait_end();
        corridor_literals();
        replay();

        // Random mazes.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N*N; i++) maze[i] = ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0;
            maze[0] = 1'b0;
            if (t % 2 == 0) maze[N*N-1] = 1'b0;
            do_reset();
            load_and_start();
            wait_end();
            replay();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
